bit_serial_multiplier_ctrl: RTL and testbench

Parallel-to-serial sequencer that owns one `bit_serial_multiplier` instance. It accepts an N-bit operand pair over a valid/ready handshake and zero-extends both operands to 2N bits. It drives the operands LSB-first into the multiplier with the `first_bit`/`last_bit` framing, reassembles the 2N-bit serial product, and returns it over a second valid/ready handshake. It sits between a parallel requester and the serial multiplier datapath; the multiplier's K parameter is 2N+1.

---
 rtl/bit_serial_multiplier_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_bit_serial_multiplier_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_multiplier_ctrl.sv
// Parallel-to-serial sequencer for a bit-serial multiplier.
// Accepts an N-bit operand pair, streams both LSB-first with
// first/last framing, reassembles the 2N-bit serial product
// and returns it over a valid/ready handshake.
//
// Ports:
//   clk, aresetn          clock, async active-low reset
//   in_valid/in_ready     operand handshake, in_a/in_b operands
//   out_valid/out_ready   product handshake, out_p product
//   busy                  operation in ARM, SHIFT or DRAIN
//   mul_x, mul_y          serial operand bits to the multiplier
//   mul_first_bit         high with bit 0 only
//   mul_last_bit          high while idle
//   mul_p                 serial product bit from the multiplier
module bit_serial_multiplier_ctrl #(
    parameter int N     = 3,
    parameter int P_LAT = 1,
    parameter int GAP   = 2
) (
    input  logic           clk,
    input  logic           aresetn,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_p,
    output logic           busy,
    output logic           mul_x,
    output logic           mul_y,
    output logic           mul_first_bit,
    output logic           mul_last_bit,
    input  logic           mul_p
);

    localparam int PW  = 2 * N;
    localparam int FR  = PW + GAP;
    localparam int CW  = $clog2(FR + 1);
    localparam int CCW = $clog2(PW + 1);

    localparam logic [CW-1:0]  SHIFT_END = CW'(PW - 1);
    localparam logic [CW-1:0]  DRAIN_END = CW'(FR - 1);
    localparam logic [CW-1:0]  LAT       = CW'(P_LAT);
    localparam logic [CCW-1:0] CAP_MAX   = CCW'(PW);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        SHIFT,
        DRAIN
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   a_sr, a_nxt;
    logic [PW-1:0]   b_sr, b_nxt;
    logic [PW-1:0]   prod, prod_nxt;
    logic [CW-1:0]   fcnt, fcnt_nxt;
    logic [CCW-1:0]  cap_cnt, cap_nxt;
    logic [PW-1:0]   out_p_nxt;
    logic            out_valid_nxt;
    logic            busy_nxt;
    logic            x_nxt, y_nxt;
    logic            first_nxt, last_nxt;
    logic            in_fire;

    // Only combinational output; held low during reset.
    assign in_ready = aresetn && (state == IDLE)
                      && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            a_sr          <= '0;
            b_sr          <= '0;
            prod          <= '0;
            fcnt          <= '0;
            cap_cnt       <= '0;
            out_p         <= '0;
            out_valid     <= 1'b0;
            busy          <= 1'b0;
            mul_x         <= 1'b0;
            mul_y         <= 1'b0;
            mul_first_bit <= 1'b0;
            mul_last_bit  <= 1'b1;
        end else begin
            state         <= state_nxt;
            a_sr          <= a_nxt;
            b_sr          <= b_nxt;
            prod          <= prod_nxt;
            fcnt          <= fcnt_nxt;
            cap_cnt       <= cap_nxt;
            out_p         <= out_p_nxt;
            out_valid     <= out_valid_nxt;
            busy          <= busy_nxt;
            mul_x         <= x_nxt;
            mul_y         <= y_nxt;
            mul_first_bit <= first_nxt;
            mul_last_bit  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        a_nxt         = a_sr;
        b_nxt         = b_sr;
        prod_nxt      = prod;
        fcnt_nxt      = fcnt;
        cap_nxt       = cap_cnt;
        out_p_nxt     = out_p;
        out_valid_nxt = out_valid;
        busy_nxt      = busy;
        x_nxt         = 1'b0;
        y_nxt         = 1'b0;
        first_nxt     = 1'b0;
        last_nxt      = 1'b0;

        // fcnt counts frame cycles from SHIFT bit 0, so product
        // bit i arrives when fcnt reaches i + P_LAT. Bits shift
        // in at the MSB; after 2N captures bit 0 sits at the LSB.
        if ((state == SHIFT || state == DRAIN)
            && fcnt >= LAT && cap_cnt != CAP_MAX) begin
            prod_nxt = {mul_p, prod[PW-1:1]};
            cap_nxt  = cap_cnt + 1'b1;
        end

        if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end

        unique case (state)
            IDLE: begin
                last_nxt = 1'b1;
                if (in_fire) begin
                    a_nxt     = {{N{1'b0}}, in_a};
                    b_nxt     = {{N{1'b0}}, in_b};
                    prod_nxt  = '0;
                    cap_nxt   = '0;
                    fcnt_nxt  = '0;
                    busy_nxt  = 1'b1;
                    last_nxt  = 1'b0;
                    state_nxt = ARM;
                end
            end
            ARM: begin
                x_nxt     = a_sr[0];
                y_nxt     = b_sr[0];
                first_nxt = 1'b1;
                a_nxt     = a_sr >> 1;
                b_nxt     = b_sr >> 1;
                fcnt_nxt  = '0;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                fcnt_nxt = fcnt + 1'b1;
                if (fcnt == SHIFT_END) begin
                    state_nxt = DRAIN;
                end else begin
                    x_nxt = a_sr[0];
                    y_nxt = b_sr[0];
                    a_nxt = a_sr >> 1;
                    b_nxt = b_sr >> 1;
                end
            end
            DRAIN: begin
                fcnt_nxt = fcnt + 1'b1;
                if (fcnt == DRAIN_END) begin
                    // Load includes a capture made on this edge.
                    out_p_nxt     = prod_nxt;
                    out_valid_nxt = 1'b1;
                    busy_nxt      = 1'b0;
                    last_nxt      = 1'b1;
                    fcnt_nxt      = '0;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bit_serial_multiplier_ctrl.sv
// Self-checking bench for bit_serial_multiplier_ctrl with a
// behavioural serial multiplier and arithmetic reference.
module tb_bit_serial_multiplier_ctrl;

    localparam int N  = 3;
    localparam int PW = 2 * N;

    logic          clk;
    logic          aresetn;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_p;
    logic          busy;
    logic          mul_x;
    logic          mul_y;
    logic          mul_first_bit;
    logic          mul_last_bit;
    logic          mul_p;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit_serial_multiplier_ctrl #(.N(N), .P_LAT(1), .GAP(2)) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_p         (out_p),
        .busy          (busy),
        .mul_x         (mul_x),
        .mul_y         (mul_y),
        .mul_first_bit (mul_first_bit),
        .mul_last_bit  (mul_last_bit),
        .mul_p         (mul_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial multiplier: product bit i depends only on operand
    // bits 0..i, and is presented one cycle after bit i.
    logic [PW-1:0] ma, mb;
    int            mi;

    function automatic logic pbit(logic [PW-1:0] a,
                                  logic [PW-1:0] b, int i);
        logic [2*PW-1:0] pr;
        pr = (2*PW)'(a) * (2*PW)'(b);
        return pr[i];
    endfunction

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            mul_p <= 1'b0;
            ma    <= '0;
            mb    <= '0;
            mi    <= 0;
        end else if (mul_last_bit) begin
            mul_p <= 1'b0;
            mi    <= 0;
        end else if (mul_first_bit) begin
            ma    <= PW'(mul_x);
            mb    <= PW'(mul_y);
            mi    <= 1;
            mul_p <= mul_x & mul_y;
        end else if (mi > 0 && mi < PW) begin
            ma    <= ma | (PW'(mul_x) << mi);
            mb    <= mb | (PW'(mul_y) << mi);
            mul_p <= pbit(ma | (PW'(mul_x) << mi),
                          mb | (PW'(mul_y) << mi), mi);
            mi    <= mi + 1;
        end else begin
            mul_p <= 1'b0;
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Accept one pair and follow it until out_valid rises.
    task automatic do_op(input int a, input int b,
                         output logic [PW-1:0] p,
                         output int lat, output int fpos,
                         output int fcount, output int lowcnt,
                         output int busycnt, output int acc);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            step();
            t++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        in_a     = N'(a);
        in_b     = N'(b);
        in_valid = 1'b1;
        acc      = cyc;
        step();
        in_valid = 1'b0;
        in_a     = N'($urandom);
        in_b     = N'($urandom);
        lat      = -1;
        fpos     = -1;
        fcount   = 0;
        lowcnt   = 0;
        busycnt  = 0;
        p        = '0;
        for (int c = 1; c <= 40; c++) begin
            if (out_valid) begin
                lat = c;
                p   = out_p;
                break;
            end
            if (mul_first_bit) begin
                fcount++;
                if (fpos < 0) fpos = c;
            end
            if (!mul_last_bit) lowcnt++;
            if (busy) busycnt++;
            step();
        end
        chk("done_in_time", 32'(lat >= 0), 32'd1);
    endtask

    int            lat, fpos, fcount, lowcnt, busycnt, acc, prev;
    logic [PW-1:0] p;
    int            order[64];
    int            ra, rb, stall, bc;

    initial begin
        aresetn   = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        step();
        chk("rst_last", 32'(mul_last_bit), 32'd1);
        chk("rst_first", 32'(mul_first_bit), 32'd0);
        chk("rst_ovalid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_inready", 32'(in_ready), 32'd0);
        chk("rst_outp", 32'(out_p), 32'd0);
        step();
        aresetn = 1'b1;
        step();

        // Single operation timing.
        do_op(3, 5, p, lat, fpos, fcount, lowcnt, busycnt, acc);
        chk("single_p", 32'(p), 32'd15);
        chk("single_lat", 32'(lat), 32'd10);
        chk("single_fpos", 32'(fpos), 32'd2);
        chk("single_fcnt", 32'(fcount), 32'd1);
        chk("single_lastlow", 32'(lowcnt), 32'd9);
        chk("single_busy", 32'(busycnt), 32'd9);

        // All 64 pairs back-to-back in shuffled order.
        for (int i = 0; i < 64; i++) order[i] = i;
        for (int i = 63; i > 0; i--) begin
            int j, tmp;
            j        = int'($urandom_range(0, i));
            tmp      = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        prev = -1;
        for (int i = 0; i < 64; i++) begin
            ra = order[i] / 8;
            rb = order[i] % 8;
            do_op(ra, rb, p, lat, fpos, fcount, lowcnt,
                  busycnt, acc);
            chk("b2b_p", 32'(p), 32'(ra * rb));
            if (prev >= 0) begin
                chk("b2b_gap", 32'(acc - prev), 32'd10);
            end
            prev = acc;
        end
        step();

        // Backpressure with an ignored request during the stall.
        out_ready = 1'b0;
        do_op(7, 7, p, lat, fpos, fcount, lowcnt, busycnt, acc);
        chk("bp_p", 32'(p), 32'd49);
        in_a     = 3'd1;
        in_b     = 3'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_hold", 32'(out_p), 32'd49);
            chk("bp_inready", 32'(in_ready), 32'd0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        chk("bp_drop", 32'(out_valid), 32'd0);
        chk("bp_nostart", 32'(busy), 32'd0);

        // Request while busy is ignored.
        do_op(6, 5, p, lat, fpos, fcount, lowcnt, busycnt, acc);
        chk("bi_first", 32'(p), 32'd30);
        step();
        in_a     = 3'd6;
        in_b     = 3'd5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        in_a     = 3'd1;
        in_b     = 3'd1;
        in_valid = 1'b1;
        #1;
        chk("bi_inready", 32'(in_ready), 32'd0);
        step();
        chk("bi_inready2", 32'(in_ready), 32'd0);
        step();
        in_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) begin
                lat = i;
                break;
            end
            step();
        end
        chk("bi_done", 32'(lat >= 0), 32'd1);
        chk("bi_p", 32'(out_p), 32'd30);
        step();
        bc = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy || out_valid) bc++;
            step();
        end
        chk("bi_no_second", 32'(bc), 32'd0);

        // Reset in the middle of SHIFT.
        in_a     = 3'd5;
        in_b     = 3'd6;
        in_valid = 1'b1;
        chk("rs_accept", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        aresetn = 1'b0;
        #1;
        chk("rs_last", 32'(mul_last_bit), 32'd1);
        chk("rs_ovalid", 32'(out_valid), 32'd0);
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_first", 32'(mul_first_bit), 32'd0);
        chk("rs_x", 32'(mul_x), 32'd0);
        chk("rs_inready", 32'(in_ready), 32'd0);
        step();
        step();
        aresetn = 1'b1;
        step();
        do_op(2, 3, p, lat, fpos, fcount, lowcnt, busycnt, acc);
        chk("rs_after_p", 32'(p), 32'd6);
        chk("rs_after_lat", 32'(lat), 32'd10);

        // Zero and edge operands.
        do_op(0, 7, p, lat, fpos, fcount, lowcnt, busycnt, acc);
        chk("edge_0x7", 32'(p), 32'd0);
        do_op(7, 1, p, lat, fpos, fcount, lowcnt, busycnt, acc);
        chk("edge_7x1", 32'(p), 32'd7);
        do_op(4, 4, p, lat, fpos, fcount, lowcnt, busycnt, acc);
        chk("edge_4x4", 32'(p), 32'd16);
        step();

        // Random pairs with random output stalls.
        for (int k = 0; k < 8; k++) begin
            ra        = int'($urandom_range(0, 7));
            rb        = int'($urandom_range(0, 7));
            stall     = int'($urandom_range(0, 4));
            out_ready = 1'b0;
            do_op(ra, rb, p, lat, fpos, fcount, lowcnt,
                  busycnt, acc);
            chk("rnd_p", 32'(p), 32'(ra * rb));
            for (int s = 0; s < stall; s++) begin
                step();
                chk("rnd_hold", 32'(out_p), 32'(ra * rb));
            end
            out_ready = 1'b1;
            step();
            chk("rnd_drop", 32'(out_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
